// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the fetch stage: NOP encoding, FSM state type and
// the {pc, inst} buffer entry layout.
package processor_defines;

    localparam logic [31:0] NOP_INST   = 32'h0000_0013;
    localparam int unsigned INST_BYTES = 4;
    // Wide enough to hold a count of 0..4 (largest legal buffer depth)
    localparam int unsigned COUNT_W    = 3;

    typedef enum logic [1:0] {
        REQ,
        WAIT,
        DROP
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_stage_buf.sv
// fetch_buf: small FIFO of {pc, inst} entries between fetch and decode.
// Flush has priority over push and pop; DEPTH must be a power of two (2 or 4).
module fetch_buf
    import processor_defines::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               push_i,
    input  logic               pop_i,
    input  logic               flush_i,
    input  fetch_entry_t       data_i,
    output fetch_entry_t       head_o,
    output logic [COUNT_W-1:0] count_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    fetch_entry_t       mem_q [DEPTH];
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               do_push, do_pop;

    // Next pointer/count values; pointers wrap naturally as DEPTH is 2^AW
    always_comb begin
        do_push  = push_i && !flush_i;
        do_pop   = pop_i && !flush_i && (count_q != '0);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + COUNT_W'(1);
                2'b01:   count_d = count_q - COUNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are only meaningful below count_q
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: holds the fetch PC, issues one-outstanding imem requests and
// buffers returned instructions for decode. Taken-branch redirects flush the
// buffer and mark any in-flight response as stale.
// Optional FETCH_PERF_CNT_EN adds push and redirect-cycle counters.
module fetch_stage
    import processor_defines::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        pc_update_control,
    input  logic [31:0] pc_update_val,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_gnt,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_imem_rdata,
    output logic        o_inst_valid,
    output logic [31:0] o_inst,
    output logic [31:0] o_inst_pc,
    input  logic        i_inst_ready
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] o_fetch_cnt,
    output logic [31:0] o_flush_cnt
`endif
);

    fetch_state_t       state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic [31:0]        req_pc_q, req_pc_d;
    logic               gnt_fire, push, pop;
    fetch_entry_t       buf_head;
    logic [COUNT_W-1:0] buf_count;

    fetch_buf #(
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk_i   (i_clk),
        .rst_ni  (i_rst),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (pc_update_control),
        .data_i  ('{pc: req_pc_q, inst: i_imem_rdata}),
        .head_o  (buf_head),
        .count_o (buf_count)
    );

    // State, fetch PC and in-flight request PC registers
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q  <= REQ;
            pc_q     <= RESET_PC;
            req_pc_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
        end
    end

    // Next state and PC; a redirect overrides the PC and retires live responses as stale
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        if (gnt_fire) begin
            req_pc_d = pc_q;
            pc_d     = pc_q + 32'(INST_BYTES);
        end
        if (pc_update_control) pc_d = pc_update_val;
        unique case (state_q)
            REQ:  if (gnt_fire) state_d = WAIT;
            WAIT: begin
                if (i_imem_rvalid)          state_d = REQ;
                else if (pc_update_control) state_d = DROP;
            end
            DROP: if (i_imem_rvalid) state_d = REQ;
            default: state_d = REQ;
        endcase
    end

    // Handshake outputs and buffer control; nothing is visible while in reset
    always_comb begin
        o_imem_req   = i_rst && (state_q == REQ) && (buf_count < COUNT_W'(BUF_DEPTH))
                       && !pc_update_control;
        gnt_fire     = o_imem_req && i_imem_gnt;
        push         = (state_q == WAIT) && i_imem_rvalid && !pc_update_control;
        o_inst_valid = i_rst && (buf_count != '0);
        pop          = o_inst_valid && i_inst_ready && !pc_update_control;
        o_inst       = o_inst_valid ? buf_head.inst : NOP_INST;
        o_inst_pc    = o_inst_valid ? buf_head.pc : '0;
        o_imem_addr  = pc_q;
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, flush_cnt_q;

    // Push and redirect-cycle counters, wrapping at 2^32
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            fetch_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (push)              fetch_cnt_q <= fetch_cnt_q + 32'd1;
            if (pc_update_control) flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

    assign o_fetch_cnt = fetch_cnt_q;
    assign o_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_fetch_stage;
    import processor_defines::*;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam int unsigned DEPTH  = 2;

    logic        i_clk = 1'b0;
    logic        i_rst, pc_update_control, i_imem_gnt, i_imem_rvalid, i_inst_ready;
    logic [31:0] pc_update_val, i_imem_rdata;
    logic        o_imem_req, o_inst_valid;
    logic [31:0] o_imem_addr, o_inst, o_inst_pc;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] o_fetch_cnt, o_flush_cnt;
`endif

    always #5 i_clk = ~i_clk;

    fetch_stage #(
        .RESET_PC  (RST_PC),
        .BUF_DEPTH (DEPTH)
    ) dut (
        .i_clk             (i_clk),
        .i_rst             (i_rst),
        .pc_update_control (pc_update_control),
        .pc_update_val     (pc_update_val),
        .o_imem_req        (o_imem_req),
        .o_imem_addr       (o_imem_addr),
        .i_imem_gnt        (i_imem_gnt),
        .i_imem_rvalid     (i_imem_rvalid),
        .i_imem_rdata      (i_imem_rdata),
        .o_inst_valid      (o_inst_valid),
        .o_inst            (o_inst),
        .o_inst_pc         (o_inst_pc),
        .i_inst_ready      (i_inst_ready)
`ifdef FETCH_PERF_CNT_EN
        ,
        .o_fetch_cnt       (o_fetch_cnt),
        .o_flush_cnt       (o_flush_cnt)
`endif
    );

    // Reference model: fetch PC, queue of {pc, inst}, and in-flight status
    // (0 = nothing outstanding, 1 = live response due, 2 = stale response due)
    logic [31:0] m_pc = RST_PC;
    logic [31:0] m_req_pc = '0;
    int          m_out = 0;
    logic [63:0] m_q[$];
    logic [31:0] m_fetch_cnt = '0;
    logic [31:0] m_flush_cnt = '0;

    logic        exp_req, exp_valid;
    logic [31:0] exp_addr, exp_inst, exp_ipc;

    int n_tests = 0;
    int n_fail  = 0;

    function automatic logic [31:0] memword(input logic [31:0] addr);
        return (addr * 32'h9E37_79B1) ^ 32'h5A5A_0013;
    endfunction

    task automatic drive(input logic rst, input logic gnt, input logic rv,
                         input logic rdy, input logic redir, input logic [31:0] val);
        i_rst             = rst;
        i_imem_gnt        = gnt;
        i_imem_rvalid     = rv;
        i_inst_ready      = rdy;
        pc_update_control = redir;
        pc_update_val     = val;
        i_imem_rdata      = (m_out != 0) ? memword(m_req_pc) : $urandom;
        #1;
        exp_valid = rst && (m_q.size() != 0);
        exp_req   = rst && (m_out == 0) && (m_q.size() < DEPTH) && !redir;
        exp_addr  = m_pc;
        exp_inst  = NOP_INST;
        exp_ipc   = '0;
        if (exp_valid) begin
            exp_inst = m_q[0][31:0];
            exp_ipc  = m_q[0][63:32];
        end
    endtask

    task automatic model_edge();
        if (!i_rst) begin
            m_pc = RST_PC;
            m_q.delete();
            m_out = 0;
            m_fetch_cnt = '0;
            m_flush_cnt = '0;
        end else if (pc_update_control) begin
            m_q.delete();
            m_pc = pc_update_val;
            m_flush_cnt = m_flush_cnt + 32'd1;
            if (m_out != 0) m_out = i_imem_rvalid ? 0 : 2;
        end else begin
            if (exp_valid && i_inst_ready) void'(m_q.pop_front());
            if (m_out == 1 && i_imem_rvalid) begin
                m_q.push_back({m_req_pc, i_imem_rdata});
                m_out = 0;
                m_fetch_cnt = m_fetch_cnt + 32'd1;
            end else if (m_out == 2 && i_imem_rvalid) begin
                m_out = 0;
            end else if (exp_req && i_imem_gnt) begin
                m_req_pc = m_pc;
                m_pc = m_pc + 32'(INST_BYTES);
                m_out = 1;
            end
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        model_edge();
        @(negedge i_clk);
    endtask

    task automatic apply_reset();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        tick();
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), $urandom);
            n_tests++;
            if (o_imem_req !== 1'b0 || o_inst_valid !== 1'b0 || o_inst !== NOP_INST || o_inst_pc !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_outputs: req=%b valid=%b inst=%h pc=%h, required 0 0 %h 00000000",
                         o_imem_req, o_inst_valid, o_inst, o_inst_pc, NOP_INST);
            end
            tick();
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        n_tests++;
        if (o_imem_req !== 1'b1 || o_imem_addr !== RST_PC) begin
            n_fail++;
            $display("FAIL reset_release: req=%b addr=%h, required 1 %h", o_imem_req, o_imem_addr, RST_PC);
        end
`ifdef FETCH_PERF_CNT_EN
        n_tests++;
        if (o_fetch_cnt !== 32'h0 || o_flush_cnt !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_counters: fetch=%0d flush=%0d, required 0 0", o_fetch_cnt, o_flush_cnt);
        end
`endif
        tick();
    endtask

    task automatic test_stream();
        int          nreq = 0;
        int          nval = 0;
        logic [31:0] addrs[3];
        logic [31:0] pcs[3];
        logic [31:0] insts[3];
        int          vcyc[3];
        apply_reset();
        for (int c = 0; c < 8; c++) begin
            drive(1'b1, 1'b1, (m_out != 0), 1'b1, 1'b0, '0);
            if (o_imem_req === 1'b1 && nreq < 3) begin
                addrs[nreq] = o_imem_addr;
                nreq++;
            end
            if (o_inst_valid === 1'b1 && nval < 3) begin
                pcs[nval]   = o_inst_pc;
                insts[nval] = o_inst;
                vcyc[nval]  = c;
                nval++;
            end
            tick();
        end
        n_tests++;
        if (nreq != 3 || nval != 3) begin
            n_fail++;
            $display("FAIL stream_counts: requests=%0d instructions=%0d, required 3 3", nreq, nval);
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_tests++;
                if (addrs[i] !== 32'(4 * i) || pcs[i] !== 32'(4 * i) || insts[i] !== memword(32'(4 * i))) begin
                    n_fail++;
                    $display("FAIL stream_seq[%0d]: addr=%h pc=%h inst=%h, required %h %h %h",
                             i, addrs[i], pcs[i], insts[i], 32'(4 * i), 32'(4 * i), memword(32'(4 * i)));
                end
            end
            n_tests++;
            if (vcyc[0] != 2 || vcyc[1] != 4 || vcyc[2] != 6) begin
                n_fail++;
                $display("FAIL stream_spacing: valid cycles %0d %0d %0d, required 2 4 6", vcyc[0], vcyc[1], vcyc[2]);
            end
        end
    endtask

    task automatic test_full();
        int nreq = 0;
        apply_reset();
        for (int c = 0; c < 8; c++) begin
            drive(1'b1, 1'b1, (m_out != 0), 1'b0, 1'b0, '0);
            if (o_imem_req === 1'b1) nreq++;
            tick();
        end
        n_tests++;
        if (nreq != int'(DEPTH)) begin
            n_fail++;
            $display("FAIL full_requests: issued %0d, required %0d", nreq, DEPTH);
        end
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, '0);
        n_tests++;
        if (o_imem_req !== 1'b0 || o_inst_valid !== 1'b1 || o_inst_pc !== 32'h0) begin
            n_fail++;
            $display("FAIL full_pop: req=%b valid=%b pc=%h, required 0 1 00000000", o_imem_req, o_inst_valid, o_inst_pc);
        end
        tick();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        n_tests++;
        if (o_imem_req !== 1'b1 || o_imem_addr !== 32'h8 || o_inst_pc !== 32'h4) begin
            n_fail++;
            $display("FAIL full_resume: req=%b addr=%h head=%h, required 1 00000008 00000004",
                     o_imem_req, o_imem_addr, o_inst_pc);
        end
        tick();
    endtask

    task automatic test_redirect_wait();
        apply_reset();
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, '0);
        tick();
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h100);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, (i == 2), 1'b1, 1'b0, '0);
            n_tests++;
            if (o_imem_req !== 1'b0 || o_inst_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL redir_drop[%0d]: req=%b valid=%b, required 0 0", i, o_imem_req, o_inst_valid);
            end
            tick();
        end
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, '0);
        n_tests++;
        if (o_imem_req !== 1'b1 || o_imem_addr !== 32'h100 || o_inst_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL redir_target: req=%b addr=%h valid=%b, required 1 00000100 0",
                     o_imem_req, o_imem_addr, o_inst_valid);
        end
        tick();
        drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, '0);
        tick();
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, '0);
        n_tests++;
        if (o_inst_valid !== 1'b1 || o_inst_pc !== 32'h100 || o_inst !== memword(32'h100)) begin
            n_fail++;
            $display("FAIL redir_data: valid=%b pc=%h inst=%h, required 1 00000100 %h",
                     o_inst_valid, o_inst_pc, o_inst, memword(32'h100));
        end
        tick();
    endtask

    task automatic test_redirect_rvalid();
        apply_reset();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        tick();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, '0);
        tick();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        tick();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h200);
        n_tests++;
        if (o_imem_req !== 1'b0 || o_inst_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL redir_rv_cycle: req=%b valid=%b, required 0 1", o_imem_req, o_inst_valid);
        end
        tick();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        n_tests++;
        if (o_inst_valid !== 1'b0 || o_imem_req !== 1'b1 || o_imem_addr !== 32'h200) begin
            n_fail++;
            $display("FAIL redir_rv_after: valid=%b req=%b addr=%h, required 0 1 00000200",
                     o_inst_valid, o_imem_req, o_imem_addr);
        end
        tick();
    endtask

    task automatic test_wrap();
        apply_reset();
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC);
        tick();
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, '0);
        tick();
        drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, '0);
        tick();
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, '0);
        n_tests++;
        if (o_imem_addr !== 32'h0 || o_imem_req !== 1'b1 || o_inst_pc !== 32'hFFFF_FFFC) begin
            n_fail++;
            $display("FAIL pc_wrap: addr=%h req=%b head=%h, required 00000000 1 fffffffc",
                     o_imem_addr, o_imem_req, o_inst_pc);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        apply_reset();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        tick();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, '0);
        tick();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h40);
        tick();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        tick();
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, '0);
        n_tests++;
        if (o_inst_valid !== 1'b0 || o_imem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_hold: valid=%b req=%b, required 0 0", o_inst_valid, o_imem_req);
        end
        tick();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        n_tests++;
        if (o_imem_req !== 1'b1 || o_imem_addr !== RST_PC || o_inst_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_release: req=%b addr=%h valid=%b, required 1 %h 0",
                     o_imem_req, o_imem_addr, o_inst_valid, RST_PC);
        end
`ifdef FETCH_PERF_CNT_EN
        n_tests++;
        if (o_fetch_cnt !== 32'h0 || o_flush_cnt !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_mid_counters: fetch=%0d flush=%0d, required 0 0", o_fetch_cnt, o_flush_cnt);
        end
`endif
        tick();
    endtask

    task automatic test_random();
        logic        rst, redir, rv;
        logic [31:0] val;
        apply_reset();
        for (int c = 0; c < 3000; c++) begin
            rst   = ($urandom_range(0, 99) != 0);
            redir = ($urandom_range(0, 9) == 0);
            val   = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : $urandom;
            rv    = (m_out != 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
            drive(rst, 1'($urandom_range(0, 1)), rv, ($urandom_range(0, 2) == 0), redir, val);
            n_tests++;
            if (o_imem_req !== exp_req || o_imem_addr !== exp_addr || o_inst_valid !== exp_valid
                || o_inst !== exp_inst || o_inst_pc !== exp_ipc) begin
                n_fail++;
                $display("FAIL random[%0d]: req=%b addr=%h valid=%b inst=%h pc=%h, required %b %h %b %h %h",
                         c, o_imem_req, o_imem_addr, o_inst_valid, o_inst, o_inst_pc,
                         exp_req, exp_addr, exp_valid, exp_inst, exp_ipc);
            end
`ifdef FETCH_PERF_CNT_EN
            n_tests++;
            if (o_fetch_cnt !== m_fetch_cnt || o_flush_cnt !== m_flush_cnt) begin
                n_fail++;
                $display("FAIL random_cnt[%0d]: fetch=%0d flush=%0d, required %0d %0d",
                         c, o_fetch_cnt, o_flush_cnt, m_fetch_cnt, m_flush_cnt);
            end
`endif
            tick();
        end
    endtask

    initial begin
        i_rst             = 1'b0;
        pc_update_control = 1'b0;
        pc_update_val     = '0;
        i_imem_gnt        = 1'b0;
        i_imem_rvalid     = 1'b0;
        i_imem_rdata      = '0;
        i_inst_ready      = 1'b0;
        @(negedge i_clk);
        test_reset();
        test_stream();
        test_full();
        test_redirect_wait();
        test_redirect_rvalid();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not complete, required completion before 1000000");
        $fatal(1, "timeout");
    end

endmodule
